fetch: RTL and testbench

Instruction fetch stage of the VGASOC CPU, sitting directly upstream of `decode`. On request it reads one 32-bit instruction from the 16-bit instruction memory bus as two halfword transactions (high then low), holds the assembled word on `o_instruction` for `decode`, and advances its program counter. A one-cycle `o_completed` pulse tells the sequencer the word is valid.

---
 rtl/fetch_if.sv | 28 ++
 rtl/fetch.sv | 130 +++++++++++++
 tb/tb_fetch.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: 16-bit instruction memory read bus between fetch and memory.
//   mem_stb  : request, held until mem_ack
//   mem_addr : halfword address of the current request
//   mem_data : read data, valid with mem_ack
//   mem_ack  : one-cycle acknowledge
// Modports: master (fetch side), slave (memory side).
interface fetch_if #(
   parameter int unsigned ADDR_WIDTH = 16
);
   logic                  mem_stb;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [15:0]           mem_data;
   logic                  mem_ack;

   modport master (
      output mem_stb,
      output mem_addr,
      input  mem_data,
      input  mem_ack
   );

   modport slave (
      input  mem_stb,
      input  mem_addr,
      output mem_data,
      output mem_ack
   );
endinterface

// File: rtl/fetch.sv
// fetch: instruction fetch stage. Reads one 32-bit instruction as two
// halfword bus reads (high word at PC, low word at PC+1), presents it on
// o_instruction with a one-cycle o_completed pulse, and advances PC by 2.
// Optional macro FETCH_TIMEOUT_EN adds a per-halfword bus timeout that
// aborts the fetch and pulses o_fault.
// Ports:
//   clk, reset          clock, async active-low reset
//   i_enable            start one fetch (IDLE only)
//   i_pc_load/i_pc_value load PC (IDLE only, wins over i_enable)
//   o_pc                current PC
//   bus                 fetch_if.master memory read bus
//   o_instruction       last fetched instruction
//   o_completed         pulse: o_instruction newly valid
//   o_fault             pulse: bus timeout (0 without FETCH_TIMEOUT_EN)
module fetch #(
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned RESET_PC       = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_enable,
   input  logic                  i_pc_load,
   input  logic [ADDR_WIDTH-1:0] i_pc_value,
   output logic [ADDR_WIDTH-1:0] o_pc,
   fetch_if.master               bus,
   output logic [31:0]           o_instruction,
   output logic                  o_completed,
   output logic                  o_fault
);

   // Timeout limit must fit the 8-bit stall counter.
   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
      $error("fetch: TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH_HI,
      ST_FETCH_LO,
      ST_DONE
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]            r_tcount;
`endif

   assign o_pc = r_pc;

   // Fetch sequencer; all outputs registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_pc          <= ADDR_WIDTH'(RESET_PC);
         bus.mem_stb   <= 1'b0;
         bus.mem_addr  <= '0;
         o_instruction <= 32'd0;
         o_completed   <= 1'b0;
         o_fault       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         r_tcount      <= 8'd0;
`endif
      end else begin
         // Pulses default low each cycle.
         o_completed <= 1'b0;
         o_fault     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_pc_load) begin
                  r_pc <= i_pc_value;
               end else if (i_enable) begin
                  r_state      <= ST_FETCH_HI;
                  bus.mem_stb  <= 1'b1;
                  bus.mem_addr <= r_pc;
`ifdef FETCH_TIMEOUT_EN
                  r_tcount     <= 8'd0;
`endif
               end
            end
            ST_FETCH_HI: begin
               if (bus.mem_ack) begin
                  o_instruction[31:16] <= bus.mem_data;
                  bus.mem_addr         <= r_pc + ADDR_WIDTH'(1);
                  r_state              <= ST_FETCH_LO;
`ifdef FETCH_TIMEOUT_EN
                  r_tcount             <= 8'd0;
               end else if (r_tcount == TIMEOUT_LAST) begin
                  bus.mem_stb <= 1'b0;
                  o_fault     <= 1'b1;
                  r_state     <= ST_IDLE;
                  r_tcount    <= 8'd0;
               end else begin
                  r_tcount <= r_tcount + 8'd1;
`endif
               end
            end
            ST_FETCH_LO: begin
               if (bus.mem_ack) begin
                  o_instruction[15:0] <= bus.mem_data;
                  bus.mem_stb         <= 1'b0;
                  r_pc                <= r_pc + ADDR_WIDTH'(2);
                  o_completed         <= 1'b1;
                  r_state             <= ST_DONE;
`ifdef FETCH_TIMEOUT_EN
                  r_tcount            <= 8'd0;
               end else if (r_tcount == TIMEOUT_LAST) begin
                  bus.mem_stb <= 1'b0;
                  o_fault     <= 1'b1;
                  r_state     <= ST_IDLE;
                  r_tcount    <= 8'd0;
               end else begin
                  r_tcount <= r_tcount + 8'd1;
`endif
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed self-checking bench for fetch with a wait-state
// programmable memory responder on the fetch_if bus.
module tb_fetch;

   logic        clk;
   logic        reset;
   logic        i_enable;
   logic        i_pc_load;
   logic [15:0] i_pc_value;
   logic [15:0] o_pc;
   logic [31:0] o_instruction;
   logic        o_completed;
   logic        o_fault;

   int checks;
   int errors;
   int waits;
   int stall;
   logic [15:0] txn_log [$];

   fetch_if #(.ADDR_WIDTH(16)) bus ();

   fetch #(
      .ADDR_WIDTH     (16),
      .RESET_PC       (0),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_enable      (i_enable),
      .i_pc_load     (i_pc_load),
      .i_pc_value    (i_pc_value),
      .o_pc          (o_pc),
      .bus           (bus),
      .o_instruction (o_instruction),
      .o_completed   (o_completed),
      .o_fault       (o_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: a few fixed words, everything else addr ^ 0xA5A5.
   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      case (a)
         16'h0000: mem_rd = 16'h1234;
         16'h0001: mem_rd = 16'h5678;
         16'h0040: mem_rd = 16'hABCD;
         16'h0041: mem_rd = 16'hEF01;
         16'hFFFF: mem_rd = 16'hCAFE;
         default:  mem_rd = a ^ 16'hA5A5;
      endcase
   endfunction

   // Responder: after 'waits' stalled edges, acks the pending request.
   always @(negedge clk) begin
      if (bus.mem_stb && reset) begin
         if (stall < waits) begin
            bus.mem_ack <= 1'b0;
            stall       <= stall + 1;
         end else begin
            bus.mem_ack  <= 1'b1;
            bus.mem_data <= mem_rd(bus.mem_addr);
            stall        <= 0;
            txn_log.push_back(bus.mem_addr);
         end
      end else begin
         bus.mem_ack <= 1'b0;
         stall       <= 0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int bad;
      logic got;
      checks = 0; errors = 0; waits = 0; stall = 0;
      bus.mem_ack = 1'b0; bus.mem_data = 16'h0000;
      reset = 1'b0; i_enable = 1'b0; i_pc_load = 1'b0; i_pc_value = 16'h0000;

      // Reset state
      tick; tick;
      chk("rst_pc", 32'(o_pc), 32'h0);
      chk("rst_stb", 32'(bus.mem_stb), 32'h0);
      chk("rst_addr", 32'(bus.mem_addr), 32'h0);
      chk("rst_instr", o_instruction, 32'h0);
      chk("rst_completed", 32'(o_completed), 32'h0);
      chk("rst_fault", 32'(o_fault), 32'h0);
      reset = 1'b1;
      tick;

      // Zero-wait fetch from PC 0
      txn_log.delete();
      i_enable = 1'b1;
      tick;
      i_enable = 1'b0;
      chk("t1_stb_hi", 32'(bus.mem_stb), 32'h1);
      chk("t1_addr_hi", 32'(bus.mem_addr), 32'h0);
      tick;
      chk("t1_addr_lo", 32'(bus.mem_addr), 32'h1);
      chk("t1_nocomp", 32'(o_completed), 32'h0);
      tick;
      chk("t1_comp", 32'(o_completed), 32'h1);
      chk("t1_instr", o_instruction, 32'h12345678);
      chk("t1_pc", 32'(o_pc), 32'h2);
      chk("t1_stb_low", 32'(bus.mem_stb), 32'h0);
      tick;
      chk("t1_comp_pulse", 32'(o_completed), 32'h0);
      chk("t1_ntxn", 32'(txn_log.size()), 32'h2);
      if (txn_log.size() == 2) begin
         chk("t1_txn0", 32'(txn_log[0]), 32'h0);
         chk("t1_txn1", 32'(txn_log[1]), 32'h1);
      end

      // PC load 0x0040, then fetch with 3 wait cycles per halfword
      i_pc_load = 1'b1; i_pc_value = 16'h0040;
      tick;
      i_pc_load = 1'b0;
      chk("t2_pc_load", 32'(o_pc), 32'h40);
      waits = 3;
      i_enable = 1'b1;
      tick;
      i_enable = 1'b0;
      chk("t2_addr_first", 32'(bus.mem_addr), 32'h40);
      cyc = 0; got = 1'b0;
      while (!got && cyc < 20) begin
         tick;
         cyc++;
         if (o_completed) got = 1'b1;
         else chk($sformatf("t2_addr_c%0d", cyc), 32'(bus.mem_addr),
                  (cyc < 4) ? 32'h40 : 32'h41);
      end
      chk("t2_latency", 32'(cyc), 32'd8);
      chk("t2_instr", o_instruction, 32'hABCDEF01);
      chk("t2_pc", 32'(o_pc), 32'h42);
      tick;

      // Wrap at PC 0xFFFF
      waits = 0;
      i_pc_load = 1'b1; i_pc_value = 16'hFFFF;
      tick;
      i_pc_load = 1'b0;
      i_enable = 1'b1;
      tick;
      i_enable = 1'b0;
      chk("t3_addr_hi", 32'(bus.mem_addr), 32'hFFFF);
      tick;
      chk("t3_addr_lo", 32'(bus.mem_addr), 32'h0000);
      tick;
      chk("t3_comp", 32'(o_completed), 32'h1);
      chk("t3_pc", 32'(o_pc), 32'h0001);
      chk("t3_instr", o_instruction, 32'hCAFE1234);
      tick;

      // i_enable/i_pc_load pulsed during FETCH_LO are ignored
      waits = 2;
      i_pc_load = 1'b1; i_pc_value = 16'h0010;
      tick;
      i_pc_load = 1'b0;
      i_enable = 1'b1;
      tick;
      i_enable = 1'b0;
      tick; tick; tick;
      chk("t4_in_lo_addr", 32'(bus.mem_addr), 32'h11);
      i_enable = 1'b1; i_pc_load = 1'b1; i_pc_value = 16'h0800;
      tick;
      chk("t4_pc_hold", 32'(o_pc), 32'h10);
      chk("t4_addr_hold", 32'(bus.mem_addr), 32'h11);
      tick;
      i_enable = 1'b0; i_pc_load = 1'b0;
      tick;
      chk("t4_comp", 32'(o_completed), 32'h1);
      chk("t4_pc", 32'(o_pc), 32'h12);
      chk("t4_instr", o_instruction, 32'hA5B5A5B4);
      tick; tick;
      chk("t4_idle_stb", 32'(bus.mem_stb), 32'h0);
      chk("t4_idle_pc", 32'(o_pc), 32'h12);

      // Reset in the middle of FETCH_LO
      i_enable = 1'b1;
      tick;
      i_enable = 1'b0;
      tick; tick; tick; tick;
      chk("t5_in_lo_stb", 32'(bus.mem_stb), 32'h1);
      chk("t5_in_lo_addr", 32'(bus.mem_addr), 32'h13);
      reset = 1'b0;
      #1;
      chk("t5_stb", 32'(bus.mem_stb), 32'h0);
      chk("t5_instr", o_instruction, 32'h0);
      chk("t5_pc", 32'(o_pc), 32'h0);
      chk("t5_comp", 32'(o_completed), 32'h0);
      tick; tick;
      chk("t5_comp_later", 32'(o_completed), 32'h0);
      reset = 1'b1;
      tick;

      // Memory never acks
      waits = 100000;
      i_enable = 1'b1;
      tick;
      i_enable = 1'b0;
      chk("t6_stb_start", 32'(bus.mem_stb), 32'h1);
`ifdef FETCH_TIMEOUT_EN
      for (int i = 1; i <= 3; i++) begin
         tick;
         chk($sformatf("t6_nofault_%0d", i), 32'(o_fault), 32'h0);
         chk($sformatf("t6_stb_%0d", i), 32'(bus.mem_stb), 32'h1);
      end
      tick;
      chk("t6_fault", 32'(o_fault), 32'h1);
      chk("t6_stb_drop", 32'(bus.mem_stb), 32'h0);
      chk("t6_pc", 32'(o_pc), 32'h0);
      chk("t6_instr", o_instruction, 32'h0);
      chk("t6_nocomp", 32'(o_completed), 32'h0);
      tick;
      chk("t6_fault_pulse", 32'(o_fault), 32'h0);
      chk("t6_idle_stb", 32'(bus.mem_stb), 32'h0);
`else
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick;
         if (bus.mem_stb !== 1'b1 || o_fault !== 1'b0 || o_completed !== 1'b0) bad++;
      end
      chk("t6_stall_bad_cycles", 32'(bad), 32'h0);
      chk("t6_addr_held", 32'(bus.mem_addr), 32'h0);
      chk("t6_pc", 32'(o_pc), 32'h0);
`endif
      waits = 0;
      reset = 1'b0;
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
